// File: rtl/nested_interrupt_controller.sv
// nested_interrupt_controller
// Fixed-priority interrupt controller. It latches CHANNELS hardware requests
// and accepts one unlatched software request. Handlers nest preemptively, with
// a hardware stack of return PCs, up to NEST_DEPTH levels deep. Each event
// (vector entry or return) produces a single registered redirect pulse to the
// PC logic.
module nested_interrupt_controller #(
  parameter int CHANNELS      = 8,
  parameter int ADDR_WIDTH    = 16,
  parameter int NEST_DEPTH    = 4,
  parameter int VECTOR_BASE   = 16'h0008,
  parameter int VECTOR_STRIDE = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [CHANNELS-1:0]                hw_irq,
  input  logic                               sw_irq,
  input  logic [3:0]                         sw_index,
  input  logic                               mask_we,
  input  logic [CHANNELS-1:0]                mask_wdata,
  input  logic [ADDR_WIDTH-1:0]              next_pc,
  input  logic                               eret,
  input  logic                               stall,
  output logic                               take,
  output logic [ADDR_WIDTH-1:0]              target_pc,
  output logic [3:0]                         cause,
  output logic [CHANNELS-1:0]                pending,
  output logic [$clog2(NEST_DEPTH+1)-1:0]    depth,
  output logic                               err
);

  localparam int DW = $clog2(NEST_DEPTH + 1);
  localparam int IW = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;
  // A level is either a channel index or CHANNELS, meaning "idle, anything may enter".
  localparam int LW = $clog2(CHANNELS + 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [LW-1:0]         lvl;
    logic [3:0]            cause;
  } frame_t;

  frame_t                stk [NEST_DEPTH];
  logic [CHANNELS-1:0]   mask;

  logic [IW-1:0]         top_idx;
  logic [IW-1:0]         push_idx;
  frame_t                top_frame;
  logic [LW-1:0]         cur_level;
  logic                  full;

  logic                  hw_hit;
  logic [3:0]            hw_idx;

  logic                  do_pop;
  logic                  do_push;
  frame_t                push_frame;
  logic                  set_err;
  logic [CHANNELS-1:0]   clr_vec;
  logic                  nxt_take;
  logic [ADDR_WIDTH-1:0] nxt_target;
  logic [3:0]            nxt_cause;

  function automatic logic [ADDR_WIDTH-1:0] vec(input logic [3:0] c);
    return ADDR_WIDTH'(VECTOR_BASE) + ADDR_WIDTH'(VECTOR_STRIDE) * ADDR_WIDTH'(c);
  endfunction

  assign top_idx   = IW'(depth - 1'b1);
  assign push_idx  = IW'(depth);
  assign top_frame = stk[top_idx];
  assign full      = (depth == DW'(NEST_DEPTH));

  // Current preemption level: that of the innermost handler, or CHANNELS when idle.
  always_comb begin
    cur_level = LW'(CHANNELS);
    if (depth != '0) cur_level = top_frame.lvl;
  end

  // Priority encoder: the lowest unmasked pending channel that strictly outranks the current level.
  always_comb begin
    hw_hit = 1'b0;
    hw_idx = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (pending[i] && !mask[i] && (LW'(i) < cur_level)) begin
        hw_hit = 1'b1;
        hw_idx = 4'(i);
      end
    end
  end

  // Per-edge decision. A pop excludes any push. Otherwise errors fall through to lower-priority sources.
  always_comb begin
    do_pop     = 1'b0;
    do_push    = 1'b0;
    push_frame = '0;
    set_err    = 1'b0;
    clr_vec    = '0;
    nxt_take   = 1'b0;
    nxt_target = '0;
    nxt_cause  = '0;
    if (!stall) begin
      if (eret && (depth != '0)) begin
        do_pop     = 1'b1;
        nxt_take   = 1'b1;
        nxt_target = top_frame.pc;
        nxt_cause  = top_frame.cause;
      end else begin
        if (eret) set_err = 1'b1;
        if (sw_irq && !full) begin
          do_push    = 1'b1;
          push_frame = '{pc: next_pc, lvl: '0, cause: sw_index};
          nxt_take   = 1'b1;
          nxt_target = vec(sw_index);
          nxt_cause  = sw_index;
        end else begin
          if (sw_irq) set_err = 1'b1;
          // A full stack leaves the hardware request pending, and raises no error.
          if (hw_hit && !full) begin
            do_push    = 1'b1;
            push_frame = '{pc: next_pc, lvl: LW'(hw_idx), cause: hw_idx};
            clr_vec    = CHANNELS'(1) << hw_idx;
            nxt_take   = 1'b1;
            nxt_target = vec(hw_idx);
            nxt_cause  = hw_idx;
          end
        end
      end
    end
  end

  // Control state. Pending accumulates and mask writes apply even while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      take      <= 1'b0;
      target_pc <= '0;
      cause     <= '0;
      pending   <= '0;
      mask      <= '0;
      depth     <= '0;
      err       <= 1'b0;
    end else begin
      pending   <= (pending & ~clr_vec) | hw_irq;
      if (mask_we) mask <= mask_wdata;
      if (set_err) err <= 1'b1;
      take      <= nxt_take;
      target_pc <= nxt_target;
      cause     <= nxt_cause;
      if (do_push)     depth <= depth + 1'b1;
      else if (do_pop) depth <= depth - 1'b1;
    end
  end

  // Stack storage. Entries above depth are don't-care, so the storage needs no reset.
  always_ff @(posedge clk) begin
    if (!rst && do_push) stk[push_idx] <= push_frame;
  end

endmodule

// File: tb/tb_nested_interrupt_controller.sv
// Scoreboard bench for nested_interrupt_controller.
// Stimulus pushes the expected redirect {target, cause}. A negedge monitor pops
// an entry and compares it on every take pulse.
module tb_nested_interrupt_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  hw_irq;
  logic        sw_irq;
  logic [3:0]  sw_index;
  logic        mask_we;
  logic [7:0]  mask_wdata;
  logic [15:0] next_pc;
  logic        eret;
  logic        stall;
  logic        take;
  logic [15:0] target_pc;
  logic [3:0]  cause;
  logic [7:0]  pending;
  logic [2:0]  depth;
  logic        err;

  typedef struct packed {
    logic [15:0] pc;
    logic [3:0]  cause;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  nested_interrupt_controller dut (
    .clk(clk), .rst(rst), .hw_irq(hw_irq), .sw_irq(sw_irq), .sw_index(sw_index),
    .mask_we(mask_we), .mask_wdata(mask_wdata), .next_pc(next_pc), .eret(eret),
    .stall(stall), .take(take), .target_pc(target_pc), .cause(cause),
    .pending(pending), .depth(depth), .err(err)
  );

  always #5 clk = ~clk;

  // Monitor: each take pulse consumes one expected redirect.
  always @(negedge clk) begin
    if (take === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_take: got target=%h cause=%0d, required no take", target_pc, cause);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (target_pc !== e.pc || cause !== e.cause) begin
          n_bad++;
          $display("FAIL redirect: got target=%h cause=%0d, required target=%h cause=%0d",
                   target_pc, cause, e.pc, e.cause);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic expect_take(input logic [15:0] pc, input logic [3:0] c);
    exp_q.push_back('{pc: pc, cause: c});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; hw_irq = '0; sw_irq = 1'b0; sw_index = '0; mask_we = 1'b0;
    mask_wdata = '0; next_pc = '0; eret = 1'b0; stall = 1'b0;
    step(); step();
    chk("rst_take", 32'(take), 0);
    chk("rst_target", 32'(target_pc), 0);
    chk("rst_cause", 32'(cause), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_depth", 32'(depth), 0);
    chk("rst_err", 32'(err), 0);
    rst = 1'b0;
    step();

    // Single hardware request, with a two-edge latency
    hw_irq = 8'h08; next_pc = 16'h0100;
    step();
    hw_irq = '0;
    chk("t1_pending", 32'(pending), 32'h08);
    chk("t1_take_early", 32'(take), 0);
    expect_take(16'h0014, 4'd3);
    step();
    chk("t1_take", 32'(take), 1);
    chk("t1_depth", 32'(depth), 1);
    chk("t1_pending_clr", 32'(pending), 0);
    step();
    chk("t1_take_once", 32'(take), 0);

    // Nesting: channel 5 is blocked while channel 1 preempts the channel-3 handler
    hw_irq = 8'h20; next_pc = 16'h0200;
    step();
    hw_irq = '0;
    step();
    chk("t2_ch5_blocked", 32'(take), 0);
    chk("t2_ch5_pending", 32'(pending), 32'h20);
    hw_irq = 8'h02;
    step();
    hw_irq = '0; next_pc = 16'h0300;
    expect_take(16'h000C, 4'd1);
    step();
    chk("t2_preempt_depth", 32'(depth), 2);
    chk("t2_preempt_pending", 32'(pending), 32'h20);
    eret = 1'b1;
    expect_take(16'h0300, 4'd1);
    step();
    chk("t2_pop1_depth", 32'(depth), 1);
    expect_take(16'h0100, 4'd3);
    step();
    eret = 1'b0;
    chk("t2_pop2_depth", 32'(depth), 0);
    next_pc = 16'h0400;
    expect_take(16'h001C, 4'd5);
    step();
    chk("t2_ch5_taken", 32'(take), 1);
    chk("t2_ch5_depth", 32'(depth), 1);
    eret = 1'b1;
    expect_take(16'h0400, 4'd5);
    step();
    eret = 1'b0;

    // Fill the stack with software interrupts, then overflow it
    sw_irq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sw_index = 4'(9 + i);
      next_pc = 16'h1000 + 16'(i);
      expect_take(16'h0008 + 16'((9 + i) * 4), 4'(9 + i));
      step();
    end
    chk("t3_full_depth", 32'(depth), 4);
    sw_index = 4'd13;
    step();
    sw_irq = 1'b0;
    chk("t3_overflow_take", 32'(take), 0);
    chk("t3_overflow_err", 32'(err), 1);
    chk("t3_overflow_depth", 32'(depth), 4);
    hw_irq = 8'h01;
    step();
    hw_irq = '0;
    step();
    chk("t3_ch0_held", 32'(pending), 32'h01);
    chk("t3_ch0_no_take", 32'(take), 0);
    // Software frames run at level 0, so channel 0 waits until they have all returned.
    eret = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      expect_take(16'h1000 + 16'(i), 4'(9 + i));
      step();
    end
    eret = 1'b0;
    next_pc = 16'h2000;
    expect_take(16'h0008, 4'd0);
    step();
    chk("t3_ch0_taken", 32'(take), 1);
    eret = 1'b1;
    expect_take(16'h2000, 4'd0);
    step();
    eret = 1'b0;

    // Same-edge eret + sw + pending hw: the pop wins and the sw request is dropped
    sw_irq = 1'b1; sw_index = 4'd2; next_pc = 16'h3000;
    expect_take(16'h0010, 4'd2);
    step();
    sw_irq = 1'b0; hw_irq = 8'h40;
    step();
    hw_irq = '0;
    chk("t4_ch6_pending", 32'(pending), 32'h40);
    eret = 1'b1; sw_irq = 1'b1; sw_index = 4'd7;
    expect_take(16'h3000, 4'd2);
    step();
    eret = 1'b0; sw_irq = 1'b0; next_pc = 16'h3100;
    chk("t4_pop_depth", 32'(depth), 0);
    expect_take(16'h0020, 4'd6);
    step();
    chk("t4_hw_depth", 32'(depth), 1);
    eret = 1'b1;
    expect_take(16'h3100, 4'd6);
    step();
    eret = 1'b0;

    // Masked channel latches its request but is not taken until unmasked
    mask_we = 1'b1; mask_wdata = 8'h04;
    step();
    mask_we = 1'b0; hw_irq = 8'h04;
    step();
    hw_irq = '0;
    step();
    chk("t5_masked_pending", 32'(pending), 32'h04);
    chk("t5_masked_take", 32'(take), 0);
    mask_we = 1'b1; mask_wdata = 8'h00;
    step();
    mask_we = 1'b0; next_pc = 16'h4000;
    chk("t5_unmask_edge", 32'(take), 0);
    expect_take(16'h0010, 4'd2);
    step();
    chk("t5_unmask_take", 32'(take), 1);
    eret = 1'b1;
    expect_take(16'h4000, 4'd2);
    step();
    eret = 1'b0;

    // Stall held for three edges
    stall = 1'b1; hw_irq = 8'h02;
    step();
    hw_irq = '0;
    step(); step();
    chk("t6_stall_take", 32'(take), 0);
    chk("t6_stall_pending", 32'(pending), 32'h02);
    stall = 1'b0; next_pc = 16'h5000;
    expect_take(16'h000C, 4'd1);
    step();
    chk("t6_release_take", 32'(take), 1);
    eret = 1'b1;
    expect_take(16'h5000, 4'd1);
    step();
    eret = 1'b0;

    // Reset in the middle of a handler and a stall
    hw_irq = 8'h02;
    step();
    hw_irq = '0; next_pc = 16'h6000;
    expect_take(16'h000C, 4'd1);
    step();
    stall = 1'b1; hw_irq = 8'h01;
    step();
    hw_irq = '0;
    rst = 1'b1;
    step();
    chk("t7_rst_take", 32'(take), 0);
    chk("t7_rst_target", 32'(target_pc), 0);
    chk("t7_rst_cause", 32'(cause), 0);
    chk("t7_rst_pending", 32'(pending), 0);
    chk("t7_rst_depth", 32'(depth), 0);
    chk("t7_rst_err", 32'(err), 0);
    rst = 1'b0; stall = 1'b0;
    step(); step();
    chk("t7_no_pulse", 32'(take), 0);

    // eret with an empty stack sets the error flag and causes no redirect
    eret = 1'b1;
    step();
    eret = 1'b0;
    chk("t8_eret_err", 32'(err), 1);
    chk("t8_eret_take", 32'(take), 0);
    chk("t8_eret_depth", 32'(depth), 0);
    step(); step();

    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
